// File: rtl/sysarray_drain.sv
// sysarray_drain: result drain for the 4x3 systolic array.
// Waits SETTLE cycles after start, snapshots c1..c12 into a shadow bank,
// then streams the twelve words row-major over a valid/ready interface.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | no pass in flight, waiting for start
//   S_WAIT   | settle down-counter running, capture on terminal count
//   S_STREAM | shadow words presented one per transfer, index 0..11
module sysarray_drain #(
    parameter int SETTLE = 10,
    parameter int DW     = 17
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] c1,
    input  logic [DW-1:0] c2,
    input  logic [DW-1:0] c3,
    input  logic [DW-1:0] c4,
    input  logic [DW-1:0] c5,
    input  logic [DW-1:0] c6,
    input  logic [DW-1:0] c7,
    input  logic [DW-1:0] c8,
    input  logic [DW-1:0] c9,
    input  logic [DW-1:0] c10,
    input  logic [DW-1:0] c11,
    input  logic [DW-1:0] c12,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [3:0]    out_index,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          overrun
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);
    localparam logic [3:0] LAST_IDX    = 4'd11;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q;
    logic [DW-1:0] shadow_q [12];
    logic [DW-1:0] live [12];

    logic          capture;
    logic          xfer;
    logic          xfer_last;
    logic [3:0]    idx_nxt;

    logic          valid_d;
    logic [DW-1:0] data_d;
    logic [3:0]    index_d;
    logic          last_d;
    logic          busy_d;
    logic          done_d;
    logic          overrun_d;

    assign live[0]  = c1;
    assign live[1]  = c2;
    assign live[2]  = c3;
    assign live[3]  = c4;
    assign live[4]  = c5;
    assign live[5]  = c6;
    assign live[6]  = c7;
    assign live[7]  = c8;
    assign live[8]  = c9;
    assign live[9]  = c10;
    assign live[10] = c11;
    assign live[11] = c12;

    assign capture   = (state_q == S_WAIT) && (cnt_q == 8'd0);
    assign xfer      = (state_q == S_STREAM) && out_valid && out_ready;
    assign xfer_last = xfer && (out_index == LAST_IDX);
    assign idx_nxt   = out_index + 4'd1;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; a start outside IDLE never changes the state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start)     state_d = S_WAIT;
            S_WAIT:   if (capture)   state_d = S_STREAM;
            S_STREAM: if (xfer_last) state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        valid_d   = out_valid;
        data_d    = out_data;
        index_d   = out_index;
        last_d    = out_last;
        busy_d    = busy;
        done_d    = 1'b0;
        overrun_d = overrun | (start && (state_q != S_IDLE));
        case (state_q)
            S_IDLE: begin
                if (start) busy_d = 1'b1;
            end
            S_WAIT: begin
                // live c1 equals the word being captured on this same edge
                if (capture) begin
                    valid_d = 1'b1;
                    data_d  = live[0];
                    index_d = 4'd0;
                    last_d  = 1'b0;
                end
            end
            S_STREAM: begin
                if (xfer_last) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (xfer) begin
                    index_d = idx_nxt;
                    data_d  = shadow_q[idx_nxt];
                    last_d  = (idx_nxt == LAST_IDX);
                end
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Settle timer, shadow bank and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= 8'd0;
            for (int i = 0; i < 12; i++) shadow_q[i] <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= 4'd0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if ((state_q == S_IDLE) && start) begin
                cnt_q <= SETTLE_LOAD;
            end else if ((state_q == S_WAIT) && (cnt_q != 8'd0)) begin
                cnt_q <= cnt_q - 8'd1;
            end
            if (capture) begin
                for (int i = 0; i < 12; i++) shadow_q[i] <= live[i];
            end
            out_valid <= valid_d;
            out_data  <= data_d;
            out_index <= index_d;
            out_last  <= last_d;
            busy      <= busy_d;
            done      <= done_d;
            overrun   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_sysarray_drain.sv
// Directed bench for sysarray_drain: basic drain, snapshot isolation,
// backpressure, overrun, mid-operation reset and full-scale words.
module tb_sysarray_drain;

    localparam int SETTLE = 10;
    localparam int DW     = 17;
    localparam logic [DW-1:0] ALL_ONES = 17'h1FFFF;

    logic          clk;
    logic          reset;
    logic          start;
    logic [DW-1:0] c_in [12];
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [3:0]    out_index;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          overrun;

    logic [DW-1:0] exp_w [12];

    int total;
    int bad;

    sysarray_drain #(.SETTLE(SETTLE), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .c1        (c_in[0]),
        .c2        (c_in[1]),
        .c3        (c_in[2]),
        .c4        (c_in[3]),
        .c5        (c_in[4]),
        .c6        (c_in[5]),
        .c7        (c_in[6]),
        .c8        (c_in[7]),
        .c9        (c_in[8]),
        .c10       (c_in[9]),
        .c11       (c_in[10]),
        .c12       (c_in[11]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"},   32'(out_valid), 32'd0);
        chk({tag, "_data"},    32'(out_data),  32'd0);
        chk({tag, "_index"},   32'(out_index), 32'd0);
        chk({tag, "_last"},    32'(out_last),  32'd0);
        chk({tag, "_busy"},    32'(busy),      32'd0);
        chk({tag, "_done"},    32'(done),      32'd0);
        chk({tag, "_overrun"}, 32'(overrun),   32'd0);
    endtask

    // Called at a sample point; asserts reset asynchronously between edges
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        chk_zero_outputs(tag);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    // Start a pass and follow it through the settle window to the first word.
    // Counting the start edge as edge 1, the first word is valid after edge SETTLE+1.
    task automatic kick(input bit iso, input int extra);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("kick_busy",  32'(busy),      32'd1);
        chk("kick_done",  32'(done),      32'd0);
        chk("kick_valid", 32'(out_valid), 32'd0);
        for (int i = 1; i <= SETTLE; i++) begin
            start = (i == extra);
            @(posedge clk); #1;
            start = 1'b0;
            if (i == SETTLE - 1) chk("pre_valid", 32'(out_valid), 32'd0);
        end
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_index", 32'(out_index), 32'd0);
        chk("first_data",  32'(out_data),  32'(exp_w[0]));
        if (iso) begin
            for (int i = 0; i < 12; i++) c_in[i] = ALL_ONES;
        end
    endtask

    // mode 0: ready always high; mode 1: ready 1,0,0 repeating.
    // start_at pulses start on the edge that transfers that index.
    // stop_at < 12 returns right after that many transfers.
    task automatic stream(input int mode, input int start_at, input int stop_at);
        int k;
        int cyc;
        bit stalled;
        bit rdy;
        logic [DW-1:0] hd;
        logic [3:0] hi;
        k = 0;
        cyc = 0;
        stalled = 1'b0;
        hd = '0;
        hi = '0;
        while (k < stop_at && cyc < 100) begin
            if (stalled) begin
                chk("hold_data",  32'(out_data),  32'(hd));
                chk("hold_index", 32'(out_index), 32'(hi));
            end
            chk("str_valid", 32'(out_valid), 32'd1);
            chk("str_done",  32'(done),      32'd0);
            rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            out_ready = rdy;
            start = rdy && (k == start_at);
            if (rdy) begin
                chk("str_data",  32'(out_data),  32'(exp_w[k]));
                chk("str_index", 32'(out_index), 32'(k));
                chk("str_last",  32'(out_last),  32'(k == 11));
                k++;
                stalled = 1'b0;
            end else begin
                hd = out_data;
                hi = out_index;
                stalled = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        out_ready = 1'b0;
        if (k < stop_at) chk("stream_timeout", 32'(k), 32'(stop_at));
        if (stop_at == 12) begin
            chk("end_valid", 32'(out_valid), 32'd0);
            chk("end_last",  32'(out_last),  32'd0);
            chk("end_busy",  32'(busy),      32'd0);
            chk("end_done",  32'(done),      32'd1);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) c_in[i] = '0;
        for (int i = 0; i < 12; i++) exp_w[i] = '0;
        #12;
        chk_zero_outputs("rst");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // basic drain, c_k = 100*k
        for (int i = 0; i < 12; i++) begin
            c_in[i]  = 17'(100 * (i + 1));
            exp_w[i] = 17'(100 * (i + 1));
        end
        kick(1'b0, 0);
        stream(0, -1, 12);

        // start on the done cycle, plus snapshot isolation
        for (int i = 0; i < 12; i++) begin
            c_in[i]  = 17'(i + 1);
            exp_w[i] = 17'(i + 1);
        end
        kick(1'b1, 0);
        chk("done_start_no_overrun", 32'(overrun), 32'd0);
        stream(0, -1, 12);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'd0);

        // backpressure with full-scale words
        for (int i = 0; i < 12; i++) begin
            c_in[i]  = ALL_ONES - 17'(i + 1);
            exp_w[i] = ALL_ONES - 17'(i + 1);
        end
        kick(1'b0, 0);
        stream(1, -1, 12);

        // overrun: extra start in WAIT, another on the final transfer edge
        for (int i = 0; i < 12; i++) begin
            c_in[i]  = 17'(100 * (i + 1) + 7);
            exp_w[i] = 17'(100 * (i + 1) + 7);
        end
        @(posedge clk); #1;
        kick(1'b0, 3);
        chk("overrun_set", 32'(overrun), 32'd1);
        stream(1, 11, 12);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        // reset during WAIT
        for (int i = 0; i < 12; i++) begin
            c_in[i]  = 17'(3 * (i + 1));
            exp_w[i] = 17'(3 * (i + 1));
        end
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("wait_busy", 32'(busy), 32'd1);
        do_reset("rst_wait");
        for (int i = 0; i < SETTLE + 3; i++) begin
            if (done !== 1'b0 || out_valid !== 1'b0) chk("rst_wait_quiet", {30'd0, done, out_valid}, 32'd0);
            @(posedge clk); #1;
        end
        chk("rst_wait_quiet_end", {30'd0, done, out_valid}, 32'd0);
        kick(1'b0, 0);
        stream(0, -1, 12);

        // reset after five transfers
        for (int i = 0; i < 12; i++) begin
            c_in[i]  = 17'h10000 + 17'(i);
            exp_w[i] = 17'h10000 + 17'(i);
        end
        @(posedge clk); #1;
        kick(1'b0, 0);
        stream(0, -1, 5);
        chk("mid_index", 32'(out_index), 32'd5);
        do_reset("rst_stream");
        chk("rst_stream_no_done", 32'(done), 32'd0);
        kick(1'b0, 0);
        stream(0, -1, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sysarray_drain.md
# sysarray_drain

Result-drain block for the 4x3 systolic array (sysarray). After the feeder starts a matrix pass, it waits a fixed settle time, snapshots all twelve 17-bit accumulator outputs c1..c12 into a shadow bank, and streams them out one word per transfer over a valid/ready interface. It sits at the output end of the array, so the array can be reset and reloaded while earlier results are still draining.

## Interface
Parameters:
- SETTLE, default 10: cycles from start to snapshot. The default is K + rows + cols - 2 = 5 + 4 + 3 - 2. Legal range is 1..255.
- DW, default 17: result word width. It matches the sysarray c outputs.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse. The feeder asserts it on the cycle it presents the first skewed operands.
- c1..c12  input  DW each  array accumulators, row-major: c1 = C[0][0], c3 = C[0][2], c4 = C[1][0], c12 = C[3][2].
- out_valid  output  1  out_data, out_index and out_last are valid.
- out_ready  input  1  downstream accepts the current word.
- out_data  output  DW  current result word.
- out_index  output  4  position of out_data, 0..11 (0 = c1).
- out_last  output  1  high with index 11.
- busy  output  1  high in WAIT or STREAM.
- done  output  1  one-cycle pulse after the last word transfers.
- overrun  output  1  sticky flag: start arrived while busy.

## Operation
- FSM states: IDLE, WAIT, STREAM.
- IDLE:
  - start=1 at an edge: go to WAIT and load the settle counter with SETTLE-1.
  - start=0: stay in IDLE.
- WAIT:
  - The counter decrements each edge.
  - On the edge where the counter is 0, capture c1..c12 into the shadow bank and go to STREAM.
  - That capture edge is exactly SETTLE edges after the start edge.
- STREAM:
  - Transfer occurs on an edge with out_valid=1 and out_ready=1.
  - On each transfer, the index increments and out_data loads the next shadow word.
  - After the transfer at index 11, go to IDLE.
- Order of words is fixed: c1, c2, …, c12, row-major.
- Shadow bank: out_data always drives the shadow word, never the live c inputs. Changes on c1..c12 after capture do not affect the stream.
- start while busy:
  - The pulse is ignored and the FSM state and counters are unchanged.
  - overrun is set and held until reset.
- start on the same edge as the final transfer: ignored as a busy start; overrun is set.
- Arithmetic: none. Words pass through unmodified at DW bits, with no truncation or sign handling.
- Reset (reset=0, at any time including mid-WAIT or mid-STREAM):
  - FSM returns to IDLE and the shadow bank clears to 0.
  - All outputs go low/0 immediately. The partial stream is abandoned; no done pulse.

## Timing
- Output reset values: out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0, overrun=0.
- All outputs are registered; there is no combinational path from out_ready to any output.
- busy rises the cycle after the start edge.
- out_valid rises the cycle after the capture edge, with out_index=0 and out_data=c1 as captured.
- Minimum latency, start edge to first word valid: SETTLE+1 edges.
- Back-to-back: with out_ready held high, one word transfers per cycle. All 12 words take 12 cycles.
- Stall: while out_valid=1 and out_ready=0, out_data, out_index and out_last hold stable.
- out_valid never drops without a transfer, except on reset.
- After the index-11 transfer, on the next cycle:
  - out_valid=0, out_last=0, busy=0;
  - done=1 for exactly one cycle.
- A new start is accepted on the cycle done is high, since the FSM is already in IDLE.

## Test plan
- Basic drain:
  - Stimulus: reset, drive c_k = 100*k constant, pulse start, out_ready=1.
  - Response: first valid word at SETTLE+1 = 11 edges after start. Words are 100, 200, …, 1200 with index 0..11 on 12 consecutive cycles. out_last only with 1200; done pulses once on the following cycle.
- Snapshot isolation:
  - Stimulus: c_k = k until the capture edge, then all c = 17'h1FFFF.
  - Response: stream is 1..12; no 1FFFF appears.
- Backpressure:
  - Stimulus: out_ready toggled 1,0,0,1,… during STREAM.
  - Response: each word holds while ready=0, with no duplicates or drops. Exactly 12 transfers occur, in order, then done.
- Overrun:
  - Stimulus: second start pulse 3 cycles after the first, and another during STREAM.
  - Response: stream is unaffected and overrun=1 after the first extra pulse.
  - Stimulus: start on the done cycle.
  - Response: accepted as a new pass.
- Reset mid-operation:
  - Stimulus: assert reset during WAIT, and in a separate run after 5 transfers.
  - Response: all outputs 0 immediately with no done pulse. A fresh start then yields a full 12-word stream beginning at index 0.
- Full-scale values:
  - Stimulus: c_k = 17'h1FFFF - k.
  - Response: exact 17-bit values are reproduced, confirming no width loss.
